// File: rtl/sigmoid_pack.sv
// sigmoid_pack: requantizes a 16-bit unsigned Q0.16 sigmoid stream to 8 bits
// (round-half-up with saturation), packs LANES samples per word and queues the
// words in a first-word-fall-through FIFO drained over valid/ready.
// A word arriving while the FIFO is full and not popping is dropped, and the
// sticky o_overflow flag is raised. The input side is never stalled.
//
// Ports:
//   clk, rst_n   clock (posedge) and asynchronous active-low reset
//   i_y          sigmoid sample, unsigned Q0.16
//   i_in_valid   i_y valid this cycle
//   i_flush      push the partially filled word, unfilled lanes zero
//   i_ready      consumer accepts o_word this cycle
//   o_word       FIFO head; lane0 in [7:0], zero when empty
//   o_out_valid  FIFO not empty
//   o_overflow   sticky: a word was dropped on a full FIFO
//   number       constant tie-off
//   o_drop_cnt   saturating dropped-word count (only with SIGMOID_PACK_STATS_EN)
//
// Optional feature macro: SIGMOID_PACK_STATS_EN
module sigmoid_pack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          i_y,
  input  logic                 i_in_valid,
  input  logic                 i_flush,
  input  logic                 i_ready,
  output logic [LANES*8-1:0]   o_word,
  output logic                 o_out_valid,
  output logic                 o_overflow,
  output logic [50:0]          number
`ifdef SIGMOID_PACK_STATS_EN
  ,
  output logic [7:0]           o_drop_cnt
`endif
);

  localparam int unsigned WORD_W = LANES * 8;
  localparam int unsigned LPTR_W = $clog2(LANES);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  // Packer state
  logic [LPTR_W-1:0] lane_ptr_q, lane_ptr_d;
  logic [7:0]        lane_q [LANES];
  logic [7:0]        lane_d [LANES];

  // FIFO state
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Registered outputs
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;

  // Combinational helpers
  logic [8:0]        sum_c;
  logic [7:0]        q_c;
  logic              push_c;
  logic              pop_c;
  logic              full_c;
  logic              wr_en_c;
  logic              drop_c;
  logic [WORD_W-1:0] word_c;
  logic [WORD_W-1:0] head_c;

  assign number = '0;

  // Round half up; a carry out of the top byte saturates to 8'hFF
  always_comb begin
    sum_c = {1'b0, i_y[15:8]} + 9'(i_y[7]);
    q_c   = sum_c[8] ? 8'hFF : sum_c[7:0];
  end

  // Packer: word assembly, push decision, lane pointer and lane registers
  always_comb begin
    word_c     = '0;
    lane_d     = lane_q;
    lane_ptr_d = lane_ptr_q;
    push_c     = (i_in_valid && (lane_ptr_q == LPTR_W'(LANES - 1))) ||
                 (i_flush && ((lane_ptr_q != '0) || i_in_valid));

    // Lanes below the pointer hold captured samples; the pointer lane takes
    // the sample arriving this cycle; everything above is zero padding.
    for (int unsigned i = 0; i < LANES; i++) begin
      if (LPTR_W'(i) < lane_ptr_q) begin
        word_c[i*8 +: 8] = lane_q[i];
      end else if ((LPTR_W'(i) == lane_ptr_q) && i_in_valid) begin
        word_c[i*8 +: 8] = q_c;
      end
    end

    if (push_c) begin
      lane_ptr_d = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        lane_d[i] = 8'h00;
      end
    end else if (i_in_valid) begin
      lane_d[lane_ptr_q] = q_c;
      lane_ptr_d         = lane_ptr_q + LPTR_W'(1);
    end
  end

  // FIFO control: pop only uses registered valid, so i_ready never reaches
  // the outputs combinationally
  always_comb begin
    pop_c      = valid_q && i_ready;
    full_c     = (count_q == CNT_W'(DEPTH));
    wr_en_c    = push_c && (!full_c || pop_c);
    drop_c     = push_c && full_c && !pop_c;
    count_d    = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
    rd_ptr_d   = pop_c   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d   = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    overflow_d = overflow_q || drop_c;

    // Next head: the word being written lands on the head slot only when the
    // FIFO is otherwise empty after this edge
    head_c     = (wr_en_c && (wr_ptr_q == rd_ptr_d)) ? word_c : mem_q[rd_ptr_d];
    valid_d    = (count_d != '0);
    word_d     = valid_d ? head_c : '0;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_ptr_q <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        lane_q[i] <= 8'h00;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      lane_ptr_q <= lane_ptr_d;
      lane_q     <= lane_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      mem_q[wr_ptr_q] <= word_c;
    end
  end

  assign o_word      = word_q;
  assign o_out_valid = valid_q;
  assign o_overflow  = overflow_q;

`ifdef SIGMOID_PACK_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating dropped-word counter
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sigmoid_pack.sv
// Directed bench for sigmoid_pack: quantize/pack, FIFO fill/overflow/drain,
// simultaneous push+pop on full, flush, asynchronous reset mid-stream and,
// with SIGMOID_PACK_STATS_EN, the saturating drop counter.
module tb_sigmoid_pack;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_y;
  logic        i_in_valid;
  logic        i_flush;
  logic        i_ready;
  logic [31:0] o_word;
  logic        o_out_valid;
  logic        o_overflow;
  logic [50:0] number;
`ifdef SIGMOID_PACK_STATS_EN
  logic [7:0]  o_drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  sigmoid_pack #(.DEPTH(4), .LANES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_y         (i_y),
    .i_in_valid  (i_in_valid),
    .i_flush     (i_flush),
    .i_ready     (i_ready),
    .o_word      (o_word),
    .o_out_valid (o_out_valid),
    .o_overflow  (o_overflow),
    .number      (number)
`ifdef SIGMOID_PACK_STATS_EN
    ,
    .o_drop_cnt  (o_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] y);
    i_y        = y;
    i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
    i_y        = 16'h0000;
  endtask

  task automatic do_reset();
    i_y = 16'h0000; i_in_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // Word whose lanes are base, base+1, base+2, base+3 (lane0 lowest)
  function automatic logic [31:0] mkword(input logic [7:0] base);
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

  // Sends one full word whose lanes quantize to base..base+3
  task automatic send_word(input logic [7:0] base);
    for (int j = 0; j < 4; j++) send({base + 8'(j), 8'h00});
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_out_valid); else n_pass++;
    n_checks++; if (o_word !== 32'h0) $display("FAIL reset_word got=%h exp=00000000", o_word); else n_pass++;
    n_checks++; if (o_overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", o_overflow); else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    i_ready = 1'b1;
    send(16'h1280);
    send(16'h0000);
    send(16'hFF80);
    send(16'h7F7F);
    n_checks++; if (o_out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", o_out_valid); else n_pass++;
    n_checks++; if (o_word !== 32'h7FFF0013) $display("FAIL basic_word got=%h exp=7fff0013", o_word); else n_pass++;
    tick();
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL basic_one_cycle got=%b exp=0", o_out_valid); else n_pass++;
    n_checks++; if (o_word !== 32'h0) $display("FAIL basic_empty_word got=%h exp=00000000", o_word); else n_pass++;
    i_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 4; k++) send_word(8'(k * 4));
    n_checks++; if (o_word !== mkword(8'd0)) $display("FAIL ovf_hold_word got=%h exp=%h", o_word, mkword(8'd0)); else n_pass++;
    n_checks++; if (o_overflow !== 1'b0) $display("FAIL ovf_not_yet got=%b exp=0", o_overflow); else n_pass++;
    send_word(8'd16);
    n_checks++; if (o_overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", o_overflow); else n_pass++;
    n_checks++; if (o_word !== mkword(8'd0)) $display("FAIL ovf_untouched got=%h exp=%h", o_word, mkword(8'd0)); else n_pass++;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_out_valid !== 1'b1 || o_word !== mkword(8'(k * 4)))
        $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", k, o_out_valid, o_word, mkword(8'(k * 4)));
      else n_pass++;
      tick();
    end
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL ovf_drained got=%b exp=0", o_out_valid); else n_pass++;
    i_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int k = 0; k < 4; k++) send_word(8'(k * 4));
    send(16'h1000);
    send(16'h1100);
    send(16'h1200);
    i_ready = 1'b1;
    send(16'h1300);
    i_ready = 1'b0;
    n_checks++; if (o_overflow !== 1'b0) $display("FAIL fpp_overflow got=%b exp=0", o_overflow); else n_pass++;
    n_checks++; if (o_word !== mkword(8'd4)) $display("FAIL fpp_head got=%h exp=%h", o_word, mkword(8'd4)); else n_pass++;
    i_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      n_checks++;
      if (o_out_valid !== 1'b1 || o_word !== mkword(8'(k * 4)))
        $display("FAIL fpp_drain%0d got=%b/%h exp=1/%h", k, o_out_valid, o_word, mkword(8'(k * 4)));
      else n_pass++;
      tick();
    end
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL fpp_drained got=%b exp=0", o_out_valid); else n_pass++;
    i_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    send(16'h0100);
    send(16'h0200);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    n_checks++; if (o_out_valid !== 1'b1 || o_word !== 32'h00000201) $display("FAIL flush_partial got=%b/%h exp=1/00000201", o_out_valid, o_word); else n_pass++;
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL flush_noop got=%b exp=0", o_out_valid); else n_pass++;
    // Flush together with a valid sample includes that sample (0x0B80 rounds to 0x0C)
    send(16'h0A00);
    i_flush = 1'b1; send(16'h0B80); i_flush = 1'b0;
    n_checks++; if (o_word !== 32'h00000C0A) $display("FAIL flush_with_valid got=%h exp=00000c0a", o_word); else n_pass++;
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    // Valid sample completing the word with flush pushes exactly one word
    send(16'h2100); send(16'h2200); send(16'h2300);
    i_flush = 1'b1; send(16'h2400); i_flush = 1'b0;
    n_checks++; if (o_word !== 32'h24232221) $display("FAIL flush_full_word got=%h exp=24232221", o_word); else n_pass++;
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL flush_single_push got=%b exp=0", o_out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) send_word(8'(k * 4));
    send(16'h5000);
    send(16'h5100);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_out_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", o_out_valid); else n_pass++;
    n_checks++; if (o_word !== 32'h0) $display("FAIL rstmid_word got=%h exp=00000000", o_word); else n_pass++;
    #1;
    rst_n = 1'b1;
    tick();
    send_word(8'h60);
    n_checks++; if (o_out_valid !== 1'b1 || o_word !== 32'h63626160) $display("FAIL rstmid_fresh got=%b/%h exp=1/63626160", o_out_valid, o_word); else n_pass++;
  endtask

`ifdef SIGMOID_PACK_STATS_EN
  task automatic test_stats();
    do_reset();
    n_checks++; if (o_drop_cnt !== 8'h00) $display("FAIL stats_reset got=%h exp=00", o_drop_cnt); else n_pass++;
    for (int k = 0; k < 5; k++) send_word(8'h00);
    n_checks++; if (o_drop_cnt !== 8'h01) $display("FAIL stats_one got=%h exp=01", o_drop_cnt); else n_pass++;
    for (int k = 5; k < 300; k++) send_word(8'h00);
    n_checks++; if (o_drop_cnt !== 8'hFF) $display("FAIL stats_sat got=%h exp=ff", o_drop_cnt); else n_pass++;
    n_checks++; if (o_overflow !== 1'b1) $display("FAIL stats_overflow got=%b exp=1", o_overflow); else n_pass++;
  endtask
`endif

  initial begin
    rst_n = 1'b0; i_y = 16'h0000; i_in_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
`ifdef SIGMOID_PACK_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
